arm_position_recorder: RTL and testbench

ARM_POSITION_RECORDER -- requirements
Module: arm_position_recorder

---
 rtl/arm_position_recorder.sv | 151 +++++++++++++++
 tb/tb_arm_position_recorder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/arm_position_recorder.sv
// Records the live arm position (three 10-bit axes) into a 16-entry position
// memory at a fixed sample rate, stopping when the memory fills or on request.
module arm_position_recorder #(
  parameter int DATA_WIDTH    = 30,
  parameter int ADDRESS_WIDTH = 4,
  parameter int CLK_FREQ      = 50_000_000,
  parameter int FREQ_SAMPLE   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_rec,
  input  logic                     stop_rec,
  input  logic [9:0]               x_in,
  input  logic [9:0]               y_in,
  input  logic [9:0]               z_in,
  output logic                     wr_en,
  output logic [ADDRESS_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0]    wr_data,
  output logic [ADDRESS_WIDTH:0]   rec_count,
  output logic                     recording,
  output logic                     full,
  output logic                     done
);

  localparam int DIV   = CLK_FREQ / FREQ_SAMPLE;
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int DEPTH = 1 << ADDRESS_WIDTH;

  localparam logic [CNT_W-1:0]       TICK_LAST = CNT_W'(DIV - 1);
  localparam logic [ADDRESS_WIDTH:0] COUNT_MAX = (ADDRESS_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, REC, FINISH} state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]    cap_q, cap_d;
  logic                     pend_q, pend_d;
  logic                     stop_pend_q, stop_pend_d;
  logic                     wr_en_q, wr_en_d;
  logic [ADDRESS_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
  logic [ADDRESS_WIDTH:0]   rec_count_q, rec_count_d;
  logic                     recording_q, recording_d;
  logic                     full_q, full_d;
  logic                     done_q, done_d;
  logic                     tick;

  assign tick = (state_q == REC) && (cnt_q == TICK_LAST);

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    cap_d       = cap_q;
    pend_d      = 1'b0;
    stop_pend_d = stop_pend_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rec_count_d = rec_count_q;
    full_d      = full_q;

    unique case (state_q)
      IDLE: begin
        if (start_rec) begin
          state_d     = REC;
          cnt_d       = '0;
          rec_count_d = '0;
          wr_addr_d   = '0;
          full_d      = 1'b0;
          stop_pend_d = 1'b0;
        end
      end

      REC: begin
        // The cycle in which a write is visible decides whether the recording ends.
        if (wr_en_q && ((rec_count_q == COUNT_MAX) || stop_pend_q)) begin
          state_d     = FINISH;
          full_d      = (rec_count_q == COUNT_MAX);
          stop_pend_d = 1'b0;
        end else begin
          cnt_d = tick ? '0 : cnt_q + 1'b1;
          if (pend_q) begin
            wr_en_d     = 1'b1;
            wr_addr_d   = rec_count_q[ADDRESS_WIDTH-1:0];
            wr_data_d   = cap_q;
            rec_count_d = rec_count_q + 1'b1;
          end else if (tick) begin
            cap_d  = DATA_WIDTH'({x_in, y_in, z_in});
            pend_d = 1'b1;
          end
          // A stop that meets an in-flight sample lets that sample land first.
          if (stop_rec) begin
            if (tick || pend_q) stop_pend_d = 1'b1;
            else                state_d     = FINISH;
          end
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    recording_d = (state_d == REC);
    done_d      = (state_d == FINISH);
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: every flop, including the capture register, is reset so an abort leaves nothing pending.
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cap_q       <= '0;
      pend_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rec_count_q <= '0;
      recording_q <= 1'b0;
      full_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cap_q       <= cap_d;
      pend_q      <= pend_d;
      stop_pend_q <= stop_pend_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rec_count_q <= rec_count_d;
      recording_q <= recording_d;
      full_q      <= full_d;
      done_q      <= done_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign rec_count = rec_count_q;
  assign recording = recording_q;
  assign full      = full_q;
  assign done      = done_q;

endmodule

// File: tb/tb_arm_position_recorder.sv
// Scoreboard bench for arm_position_recorder with DIV = 4: stimulus pushes the
// expected writes/done pulses, a negedge monitor pops and compares them.
module tb_arm_position_recorder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_rec, stop_rec;
  logic [9:0] x_in, y_in, z_in;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [29:0] wr_data;
  logic [4:0] rec_count;
  logic       recording, full, done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          addr;
    logic [29:0] data;
    int          cyc;
  } wr_exp_t;

  typedef struct {
    int cyc;
    int rc;
    int full;
  } done_exp_t;

  wr_exp_t   wq[$];
  done_exp_t dq[$];

  arm_position_recorder #(
    .DATA_WIDTH(30), .ADDRESS_WIDTH(4), .CLK_FREQ(4), .FREQ_SAMPLE(1)
  ) dut (
    .clk(clk), .rst(rst), .start_rec(start_rec), .stop_rec(stop_rec),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rec_count(rec_count), .recording(recording), .full(full), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Sample m of a run drives x=v, y=v+100, z=v+200 with v = xoff+m.
  function automatic logic [29:0] pack(input int v);
    logic [9:0] x, y, z;
    x = 10'(v);
    y = 10'(v + 100);
    z = 10'(v + 200);
    return {x, y, z};
  endfunction

  // Write k is captured on the tick edge 4(k+1) after start and visible two edges later.
  task automatic push_writes(input int base, input int n, input int xoff);
    wr_exp_t e;
    for (int k = 0; k < n; k++) begin
      e.addr = k;
      e.data = pack(xoff + 4 * (k + 1));
      e.cyc  = base + 4 * k + 6;
      wq.push_back(e);
    end
  endtask

  task automatic push_done(input int c, input int rc, input int f);
    done_exp_t e;
    e.cyc  = c;
    e.rc   = rc;
    e.full = f;
    dq.push_back(e);
  endtask

  task automatic run_rec(input int xoff, input int ncyc, input int stop_m, input int start_m);
    for (int m = 0; m < ncyc; m++) begin
      start_rec = (m == 0) || (m == start_m);
      stop_rec  = (m == stop_m);
      x_in = 10'(xoff + m);
      y_in = 10'(xoff + m + 100);
      z_in = 10'(xoff + m + 200);
      if (m == 1) begin
        check("start_full_clear", full, 0);
        check("start_count_clear", rec_count, 0);
        check("start_addr_clear", wr_addr, 0);
        check("start_recording", recording, 1);
      end
      @(negedge clk);
    end
    start_rec = 1'b0;
    stop_rec  = 1'b0;
  endtask

  // Monitor: every write and done pulse must match the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) begin
        if (wq.size() == 0) check("spurious_wr_en", wr_en, 0);
        else begin
          wr_exp_t e;
          e = wq.pop_front();
          check("wr_addr", wr_addr, e.addr);
          check("wr_data", wr_data, e.data);
          check("wr_cycle", cyc, e.cyc);
          check("wr_count", rec_count, e.addr + 1);
        end
      end
      if (done) begin
        if (dq.size() == 0) check("spurious_done", done, 0);
        else begin
          done_exp_t d;
          d = dq.pop_front();
          check("done_cycle", cyc, d.cyc);
          check("done_count", rec_count, d.rc);
          check("done_full", full, d.full);
          check("done_recording", recording, 0);
        end
      end
    end
  end

  initial begin
    int base;
    rst = 1'b1;
    start_rec = 1'b0;
    stop_rec  = 1'b0;
    x_in = '0;
    y_in = '0;
    z_in = '0;

    #3;
    check("rst_wr_en", wr_en, 0);
    check("rst_rec_count", rec_count, 0);
    check("rst_recording", recording, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_no_activity", recording, 0);

    // Basic record of (100,200,300), then an asynchronous abort mid-recording.
    base = cyc;
    push_writes(base, 1, 96);
    run_rec(96, 8, -1, -1);
    check("pre_abort_count", rec_count, 1);
    #2 rst = 1'b1;
    #1;
    check("abort_wr_en", wr_en, 0);
    check("abort_wr_addr", wr_addr, 0);
    check("abort_wr_data", wr_data, 0);
    check("abort_rec_count", rec_count, 0);
    check("abort_recording", recording, 0);
    check("abort_full", full, 0);
    check("abort_done", done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("post_abort_idle", recording, 0);
    check("post_abort_count", rec_count, 0);

    // Early stop after three writes, clear of any tick.
    base = cyc;
    push_writes(base, 3, 0);
    push_done(base + 16, 3, 0);
    run_rec(0, 24, 15, -1);

    // Stop coincident with a tick; a stray start mid-recording is ignored.
    base = cyc;
    push_writes(base, 2, 300);
    push_done(base + 11, 2, 0);
    run_rec(300, 20, 8, 3);

    // Fill the memory: 16 writes, one done, no wrap.
    base = cyc;
    push_writes(base, 16, 10);
    push_done(base + 67, 16, 1);
    run_rec(10, 80, -1, -1);
    check("full_flag", full, 1);
    check("full_count", rec_count, 16);
    check("full_last_addr", wr_addr, 15);
    check("full_idle", recording, 0);

    // Restart after full overwrites from address 0.
    base = cyc;
    push_writes(base, 1, 500);
    push_done(base + 8, 1, 0);
    run_rec(500, 12, 7, -1);

    repeat (3) @(negedge clk);
    check("writes_outstanding", wq.size(), 0);
    check("dones_outstanding", dq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
